// File: rtl/i1_pkg.sv
// Shared types and constants for the i1 phase controller slice.
package i1_pkg;

  localparam int PHASE_W = 3;
  localparam logic [PHASE_W-1:0] PHASE_FIRST = 3'd1;
  localparam logic [PHASE_W-1:0] PHASE_LAST  = 3'd7;
  localparam int STROBE_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/i1_phase_cnt.sv
// Phase counter (0 when inactive, 1..7 while running) with one-hot strobe decode.
module i1_phase_cnt
  import i1_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [PHASE_W-1:0]  phase,
  output logic [STROBE_W-1:0] pv7
);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;

  // Entering RUN is an increment from 0, so phase 1 needs no separate load.
  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (inc && (phase_q != PHASE_LAST)) begin
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase 0 matches no strobe, which keeps every strobe low outside RUN.
  always_comb begin
    pv7 = '0;
    for (int k = 0; k < STROBE_W; k++) begin
      if (phase_q == PHASE_W'(k + int'(PHASE_FIRST))) begin
        pv7[k] = 1'b1;
      end
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/i1_phase_ctrl.sv
// IDLE/RUN/DONE phase sequencer with latched request flags and gated downstream state bits.
// Optional freeze input enabled by defining I1_PHASE_HOLD_EN.
module i1_phase_ctrl
  import i1_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic step,
  input  logic req,
  input  logic mode,
  input  logic nxt27_1,
  input  logic nxt27_4,
`ifdef I1_PHASE_HOLD_EN
  input  logic hold,
`endif
  output logic pv7_1,
  output logic pv7_2,
  output logic pv7_3,
  output logic pv7_4,
  output logic pv7_5,
  output logic pv7_6,
  output logic pv7_7,
  output logic pv8_0,
  output logic pv9_0,
  output logic pv27_0,
  output logic pv27_3,
  output logic pv29_0,
  output logic done
);

  state_e state_q;
  state_e state_d;

  logic                frozen;
  logic                cntInc;
  logic                cntClr;
  logic                capture;
  logic                pvUpdate;
  logic [PHASE_W-1:0]  phase;
  logic [STROBE_W-1:0] pv7;

  logic reqLat_q,  reqLat_d;
  logic modeLat_q, modeLat_d;
  logic pv27a_q,   pv27a_d;
  logic pv27b_q,   pv27b_d;

`ifdef I1_PHASE_HOLD_EN
  assign frozen = hold;
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!frozen) begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (step && (phase == PHASE_LAST)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Step in IDLE is ignored; the start pulse alone moves the counter 0 -> 1.
  always_comb begin
    pv29_0   = (state_q == RUN);
    done     = (state_q == DONE);
    cntInc   = 1'b0;
    cntClr   = 1'b0;
    capture  = 1'b0;
    pvUpdate = 1'b0;
    if (!frozen) begin
      case (state_q)
        IDLE: begin
          cntInc  = start;
          capture = start;
        end
        RUN: begin
          pvUpdate = step;
          if (step) begin
            if (phase == PHASE_LAST) cntClr = 1'b1;
            else                     cntInc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    reqLat_d  = capture  ? req     : reqLat_q;
    modeLat_d = capture  ? mode    : modeLat_q;
    pv27a_d   = pvUpdate ? nxt27_1 : pv27a_q;
    pv27b_d   = pvUpdate ? nxt27_4 : pv27b_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reqLat_q  <= 1'b0;
      modeLat_q <= 1'b0;
      pv27a_q   <= 1'b0;
      pv27b_q   <= 1'b0;
    end else begin
      reqLat_q  <= reqLat_d;
      modeLat_q <= modeLat_d;
      pv27a_q   <= pv27a_d;
      pv27b_q   <= pv27b_d;
    end
  end

  i1_phase_cnt uPhaseCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cntClr),
    .inc   (cntInc),
    .phase (phase),
    .pv7   (pv7)
  );

  assign pv7_1  = pv7[0];
  assign pv7_2  = pv7[1];
  assign pv7_3  = pv7[2];
  assign pv7_4  = pv7[3];
  assign pv7_5  = pv7[4];
  assign pv7_6  = pv7[5];
  assign pv7_7  = pv7[6];
  assign pv8_0  = reqLat_q;
  assign pv9_0  = modeLat_q;
  assign pv27_0 = pv27a_q;
  assign pv27_3 = pv27b_q;

endmodule

// File: tb/tb_i1_phase_ctrl.sv
// Directed vector bench for i1_phase_ctrl; the hold sequence runs only when I1_PHASE_HOLD_EN is defined.
module tb_i1_phase_ctrl;

  logic clk = 1'b0;
  logic rst, start, step, req, mode, nxt27_1, nxt27_4;
  logic pv7_1, pv7_2, pv7_3, pv7_4, pv7_5, pv7_6, pv7_7;
  logic pv8_0, pv9_0, pv27_0, pv27_3, pv29_0, done;
`ifdef I1_PHASE_HOLD_EN
  logic hold = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;

  // stim = {rst,start,step,req,mode,nxt27_1,nxt27_4}; eFlags = {pv8,pv9,pv27_0,pv27_3,pv29,done}
  typedef struct {
    logic [6:0] stim;
    int         ePhase;
    logic [5:0] eFlags;
  } vec_t;

  vec_t vecs[22];

  always #5 clk = ~clk;

  i1_phase_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .step    (step),
    .req     (req),
    .mode    (mode),
    .nxt27_1 (nxt27_1),
    .nxt27_4 (nxt27_4),
`ifdef I1_PHASE_HOLD_EN
    .hold    (hold),
`endif
    .pv7_1   (pv7_1),
    .pv7_2   (pv7_2),
    .pv7_3   (pv7_3),
    .pv7_4   (pv7_4),
    .pv7_5   (pv7_5),
    .pv7_6   (pv7_6),
    .pv7_7   (pv7_7),
    .pv8_0   (pv8_0),
    .pv9_0   (pv9_0),
    .pv27_0  (pv27_0),
    .pv27_3  (pv27_3),
    .pv29_0  (pv29_0),
    .done    (done)
  );

  function automatic logic [6:0] oneHot(input int p);
    logic [6:0] r;
    r = '0;
    if (p >= 1 && p <= 7) r[p-1] = 1'b1;
    return r;
  endfunction

  task automatic applyStimulus(input logic [6:0] s);
    {rst, start, step, req, mode, nxt27_1, nxt27_4} = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int ePhase, input logic [5:0] eFlags);
    logic [12:0] act;
    logic [12:0] exp;
    act = {pv7_7, pv7_6, pv7_5, pv7_4, pv7_3, pv7_2, pv7_1,
           pv8_0, pv9_0, pv27_0, pv27_3, pv29_0, done};
    exp = {oneHot(ePhase), eFlags};
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got strobes=%b flags=%b, expected strobes=%b flags=%b",
               name, act[12:6], act[5:0], exp[12:6], exp[5:0]);
    end
  endtask

  initial begin
    {rst, start, step, req, mode, nxt27_1, nxt27_4} = 7'b1_0_0_0_0_0_0;

    vecs[0]  = '{7'b1_0_0_0_0_0_0, 0, 6'b00_00_0_0};
    vecs[1]  = '{7'b0_1_0_1_0_0_0, 1, 6'b10_00_1_0};
    vecs[2]  = '{7'b0_0_1_0_0_1_0, 2, 6'b10_10_1_0};
    vecs[3]  = '{7'b0_0_0_0_0_0_1, 2, 6'b10_10_1_0};
    vecs[4]  = '{7'b0_0_0_0_0_0_1, 2, 6'b10_10_1_0};
    vecs[5]  = '{7'b0_0_1_0_0_0_1, 3, 6'b10_01_1_0};
    vecs[6]  = '{7'b0_0_1_0_0_1_1, 4, 6'b10_11_1_0};
    vecs[7]  = '{7'b0_1_0_0_1_0_0, 4, 6'b10_11_1_0};
    vecs[8]  = '{7'b0_1_1_0_1_0_0, 5, 6'b10_00_1_0};
    vecs[9]  = '{7'b0_0_1_0_0_1_0, 6, 6'b10_10_1_0};
    vecs[10] = '{7'b0_0_1_0_0_0_1, 7, 6'b10_01_1_0};
    vecs[11] = '{7'b0_0_1_0_0_1_1, 0, 6'b10_11_0_1};
    vecs[12] = '{7'b0_0_1_0_0_0_0, 0, 6'b10_11_0_0};
    vecs[13] = '{7'b0_0_1_0_0_0_0, 0, 6'b10_11_0_0};
    vecs[14] = '{7'b0_1_1_0_1_0_0, 1, 6'b01_11_1_0};
    vecs[15] = '{7'b0_0_1_0_0_0_0, 2, 6'b01_00_1_0};
    vecs[16] = '{7'b0_0_1_0_0_0_0, 3, 6'b01_00_1_0};
    vecs[17] = '{7'b0_0_1_0_0_1_0, 4, 6'b01_10_1_0};
    vecs[18] = '{7'b0_0_1_0_0_1_0, 5, 6'b01_10_1_0};
    vecs[19] = '{7'b1_1_1_1_1_1_1, 0, 6'b00_00_0_0};
    vecs[20] = '{7'b0_1_0_1_1_0_0, 1, 6'b11_00_1_0};
    vecs[21] = '{7'b0_0_1_0_0_0_1, 2, 6'b11_01_1_0};

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("vec%0d", i), vecs[i].ePhase, vecs[i].eFlags);
    end

    // Full seven-step walk, then start during DONE must not relaunch.
    applyStimulus(7'b1_0_0_0_0_0_0);
    checkOutput("seqReset", 0, 6'b00_00_0_0);
    applyStimulus(7'b0_1_0_1_0_0_0);
    checkOutput("seqStart", 1, 6'b10_00_1_0);
    for (int k = 2; k <= 7; k++) begin
      applyStimulus(7'b0_0_1_0_0_0_0);
      checkOutput($sformatf("seqPhase%0d", k), k, 6'b10_00_1_0);
    end
    applyStimulus(7'b0_0_1_0_0_0_0);
    checkOutput("seqDone", 0, 6'b10_00_0_1);
    applyStimulus(7'b0_1_0_0_1_0_0);
    checkOutput("seqIdleAfterDone", 0, 6'b10_00_0_0);
    applyStimulus(7'b0_0_0_0_0_0_0);
    checkOutput("seqStaysIdle", 0, 6'b10_00_0_0);

`ifdef I1_PHASE_HOLD_EN
    applyStimulus(7'b1_0_0_0_0_0_0);
    checkOutput("holdReset", 0, 6'b00_00_0_0);
    applyStimulus(7'b0_1_0_1_1_0_0);
    checkOutput("holdStart", 1, 6'b11_00_1_0);
    applyStimulus(7'b0_0_1_0_0_0_0);
    checkOutput("holdPhase2", 2, 6'b11_00_1_0);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(7'b0_1_1_0_0_1_1);
      checkOutput($sformatf("holdFrozen%0d", k), 2, 6'b11_00_1_0);
    end
    hold = 1'b0;
    applyStimulus(7'b0_0_1_0_0_1_1);
    checkOutput("holdResume", 3, 6'b11_11_1_0);
    hold = 1'b1;
    applyStimulus(7'b1_0_1_0_0_0_0);
    checkOutput("holdResetWins", 0, 6'b00_00_0_0);
    hold = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/i1_phase_ctrl.md
I1_PHASE_CTRL -- requirements
Module: i1_phase_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  single system clock, all state updates on its rising edge.
REQ-002 SHALL provide: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: start  in  1  sequence-begin pulse, honoured only in IDLE.
REQ-004 SHALL provide: step  in  1  phase-advance qualifier.
REQ-005 SHALL provide: req  in  1  request flag, captured to pv8_0 at start acceptance.
REQ-006 SHALL provide: mode  in  1  mode flag, captured to pv9_0 at start acceptance.
REQ-007 SHALL provide: nxt27_1  in  1  downstream next-state bit for pv27_0.
REQ-008 SHALL provide: nxt27_4  in  1  downstream next-state bit for pv27_3.
REQ-009 SHALL provide: pv7_1 .. pv7_7  out  1 each  one-hot phase strobes, all low outside RUN.
REQ-010 SHALL provide: pv8_0, pv9_0  out  1 each  latched req/mode.
REQ-011 SHALL provide: pv27_0, pv27_3  out  1 each  registered state bits fed to the downstream decode.
REQ-012 SHALL provide: pv29_0  out  1  sequence-active enable, high exactly in RUN.
REQ-013 SHALL provide: done  out  1  one-cycle end-of-sequence pulse.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE, with a 3-bit phase counter holding values 1..7 in RUN.
REQ-015 SHALL move IDLE->RUN on start=1, with phase=1, pv7_1=1 and pv29_0=1 visible on the next cycle (1-cycle latency).
REQ-016 SHALL, in RUN with step=1 and phase<7, increment phase by 1; with step=0, phase and strobes SHALL hold.
REQ-017 SHALL, in RUN with step=1 and phase=7, go to DONE, so that all pv7 strobes are low and pv29_0=0 next cycle; no wrap to phase 1.
REQ-018 SHALL go DONE->IDLE unconditionally, asserting done=1 only during the DONE cycle.
REQ-019 SHALL ignore start in RUN and DONE; start and step both high in IDLE SHALL start the sequence only, with the step ignored.
REQ-020 SHALL drive exactly one pv7_k high in RUN, where k=phase, and none otherwise.
REQ-021 SHALL capture req->pv8_0 and mode->pv9_0 on the start-accept edge and hold them through RUN, DONE and IDLE until the next accepted start.
REQ-022 SHALL update pv27_0<=nxt27_1 and pv27_3<=nxt27_4 only on cycles with pv29_0=1 and step=1, including the phase-7 exit step, and hold them otherwise.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, force state to IDLE, phase to 0 and all outputs to 0 (pv7_*, pv8_0, pv9_0, pv27_0, pv27_3, pv29_0, done), from any state including mid-RUN.
REQ-024 SHALL give rst priority over start, step and all data inputs in the same cycle.

Configuration
REQ-025 SHALL support macro I1_PHASE_HOLD_EN; when it is defined, an extra input "hold" (1 bit) SHALL freeze all state, including the FSM, phase, pv27_* and done generation, whenever it is high, with rst still overriding it.
REQ-026 SHALL, without I1_PHASE_HOLD_EN, have no hold port and behave exactly as REQ-014..REQ-024.

Structure
REQ-027 SHALL take from shared package i1_pkg the FSM state enum (IDLE/RUN/DONE), PHASE_W=3, PHASE_FIRST=1 and PHASE_LAST=7.
REQ-028 SHALL place the phase counter plus one-hot decode in sub-module i1_phase_cnt (inputs clk, rst, clr, inc; outputs phase and pv7 vector), with the FSM in the top.

Verification
REQ-029 SHALL check reset then start=1, req=1, mode=0 -> next cycle pv7_1=1, pv29_0=1, pv8_0=1, pv9_0=0.
REQ-030 SHALL check 7 consecutive step=1 cycles after start -> pv7_1..pv7_7 in order, then all low with done=1 one cycle later and IDLE after that.
REQ-031 SHALL check step toggling 1,0,0,1 in RUN -> phase advances only on step=1 cycles, and pv27_0 follows nxt27_1 only on those cycles.
REQ-032 SHALL check start=1 asserted in RUN at phase 4 -> no effect, pv8_0/pv9_0 unchanged, phase continues.
REQ-033 SHALL check rst=1 at phase 5 -> next cycle all outputs 0, and a following start restarts at phase 1.
REQ-034 SHALL check, with I1_PHASE_HOLD_EN defined, hold=1 for 3 cycles at phase 2 with step=1 -> phase stays 2 and pv27_* stay frozen, then advancing resumes once hold=0.
